// File: rtl/chrowbuf_db_if.sv
// Bus bundle for the double-buffered character row store: read port, write port,
// commit/consume strobes and status flags.
interface chrowbuf_db_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) ();
  logic              rd;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              fill_done;
  logic              row_done;
  logic              front_bank;
  logic              wr_ready;
  logic              swap;
  logic              underrun;

  modport master (
    output rd, rd_addr, wr, wr_addr, wr_data, fill_done, row_done,
    input  rd_data, front_bank, wr_ready, swap, underrun
  );

  modport slave (
    input  rd, rd_addr, wr, wr_addr, wr_data, fill_done, row_done,
    output rd_data, front_bank, wr_ready, swap, underrun
  );
endinterface

// File: rtl/chrowbuf_db.sv
// Double-buffered character row buffer: the writer fills the back bank while the
// reader scans the front bank; banks swap when both sides have finished.
module chrowbuf_db #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  chrowbuf_db_if.slave  bus
);
  localparam int WORDS = 2 * (2 ** ADDR_W);

  typedef enum logic {FILLING = 1'b0, FULL = 1'b1} state_t;

  state_t            state, state_n;
  logic              front_q;
  logic              swap_q;
  logic              underrun_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              toggle;
  logic              set_underrun;
  logic              wr_en;
  logic              rd_en;

  logic [DATA_W-1:0] mem [0:WORDS-1];

  // Strobes are active-low; nothing is accepted while reset is held.
  assign wr_en = !rst && !bus.wr && (state == FILLING);
  assign rd_en = !rst && !bus.rd;

  always_comb begin
    state_n      = state;
    toggle       = 1'b0;
    set_underrun = 1'b0;
    case (state)
      FILLING: begin
        if (!bus.fill_done && !bus.row_done) begin
          toggle = 1'b1;
        end else if (!bus.fill_done) begin
          state_n = FULL;
        end else if (!bus.row_done) begin
          set_underrun = 1'b1;
        end
      end
      FULL: begin
        if (!bus.row_done) begin
          toggle  = 1'b1;
          state_n = FILLING;
        end
      end
      default: state_n = FILLING;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILLING;
      front_q    <= 1'b0;
      swap_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_n;
      front_q    <= front_q ^ toggle;
      swap_q     <= toggle;
      underrun_q <= underrun_q | set_underrun;
    end
  end

  // Storage has no reset so it maps onto a simple dual-port block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{~front_q, bus.wr_addr}] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[{front_q, bus.rd_addr}];
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.front_bank = front_q;
  assign bus.wr_ready   = (state == FILLING);
  assign bus.swap       = swap_q;
  assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_chrowbuf_db.sv
// Directed bench for chrowbuf_db: default-size instance plus an 8-bit/16-word instance.
module tb_chrowbuf_db;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  chrowbuf_db_if #(.DATA_W(16), .ADDR_W(8)) b1 ();
  chrowbuf_db_if #(.DATA_W(8),  .ADDR_W(4)) b2 ();

  chrowbuf_db #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  chrowbuf_db #(.DATA_W(8), .ADDR_W(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives every input of the default instance (strobes active-low), then clocks once.
  task automatic applyStimulus(input logic rd, input logic [7:0] ra, input logic wr,
                               input logic [7:0] wa, input logic [15:0] wd,
                               input logic fd, input logic rdn);
    b1.rd        = rd;
    b1.rd_addr   = ra;
    b1.wr        = wr;
    b1.wr_addr   = wa;
    b1.wr_data   = wd;
    b1.fill_done = fd;
    b1.row_done  = rdn;
    tick();
  endtask

  task automatic applySmall(input logic rd, input logic [3:0] ra, input logic wr,
                            input logic [3:0] wa, input logic [7:0] wd,
                            input logic fd, input logic rdn);
    b2.rd        = rd;
    b2.rd_addr   = ra;
    b2.wr        = wr;
    b2.wr_addr   = wa;
    b2.wr_data   = wd;
    b2.fill_done = fd;
    b2.row_done  = rdn;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    b1.rd = 1'b1; b1.rd_addr = '0; b1.wr = 1'b1; b1.wr_addr = '0; b1.wr_data = '0;
    b1.fill_done = 1'b1; b1.row_done = 1'b1;
    b2.rd = 1'b1; b2.rd_addr = '0; b2.wr = 1'b1; b2.wr_addr = '0; b2.wr_data = '0;
    b2.fill_done = 1'b1; b2.row_done = 1'b1;
    #2;
    checkOutput("rst_wr_ready", 32'(b1.wr_ready), 32'd1);
    checkOutput("rst_front", 32'(b1.front_bank), 32'd0);
    checkOutput("rst_swap", 32'(b1.swap), 32'd0);
    checkOutput("rst_underrun", 32'(b1.underrun), 32'd0);
    checkOutput("rst_rd_data", 32'(b1.rd_data), 32'd0);
    tick();
    rst = 1'b0;

    // Write on the commit edge lands in bank 1.
    applyStimulus(1'b1, 8'd0, 1'b0, 8'd5, 16'hA541, 1'b0, 1'b1);
    checkOutput("fill_full_wr_ready", 32'(b1.wr_ready), 32'd0);
    checkOutput("fill_front", 32'(b1.front_bank), 32'd0);
    applyStimulus(1'b1, 8'd0, 1'b0, 8'd5, 16'h1234, 1'b0, 1'b1);
    checkOutput("full_ignore_wr_ready", 32'(b1.wr_ready), 32'd0);
    checkOutput("full_ignore_swap", 32'(b1.swap), 32'd0);
    applyStimulus(1'b1, 8'd0, 1'b1, 8'd0, 16'h0, 1'b1, 1'b0);
    checkOutput("swap1_pulse", 32'(b1.swap), 32'd1);
    checkOutput("swap1_front", 32'(b1.front_bank), 32'd1);
    checkOutput("swap1_wr_ready", 32'(b1.wr_ready), 32'd1);
    checkOutput("swap1_underrun", 32'(b1.underrun), 32'd0);
    applyStimulus(1'b1, 8'd0, 1'b1, 8'd0, 16'h0, 1'b1, 1'b1);
    checkOutput("swap1_one_cycle", 32'(b1.swap), 32'd0);

    // Read bank 1 while writing bank 0; the FULL-state write must not have landed.
    applyStimulus(1'b0, 8'd5, 1'b0, 8'd5, 16'h0BEE, 1'b1, 1'b1);
    checkOutput("read_a541", 32'(b1.rd_data), 32'hA541);
    applyStimulus(1'b1, 8'd9, 1'b1, 8'd0, 16'h0, 1'b1, 1'b1);
    checkOutput("read_hold", 32'(b1.rd_data), 32'hA541);
    applyStimulus(1'b1, 8'd0, 1'b0, 8'd7, 16'h7777, 1'b0, 1'b1);
    checkOutput("fill2_wr_ready", 32'(b1.wr_ready), 32'd0);

    // Read on the toggle edge still sees the old front bank.
    applyStimulus(1'b0, 8'd5, 1'b1, 8'd0, 16'h0, 1'b1, 1'b0);
    checkOutput("toggle_read_old", 32'(b1.rd_data), 32'hA541);
    checkOutput("swap2_front", 32'(b1.front_bank), 32'd0);
    checkOutput("swap2_pulse", 32'(b1.swap), 32'd1);
    applyStimulus(1'b0, 8'd5, 1'b1, 8'd0, 16'h0, 1'b1, 1'b1);
    checkOutput("read_0bee", 32'(b1.rd_data), 32'h0BEE);

    // Underrun: row_done with nothing committed.
    applyStimulus(1'b1, 8'd0, 1'b1, 8'd0, 16'h0, 1'b1, 1'b0);
    checkOutput("ur_flag", 32'(b1.underrun), 32'd1);
    checkOutput("ur_front", 32'(b1.front_bank), 32'd0);
    checkOutput("ur_swap", 32'(b1.swap), 32'd0);
    checkOutput("ur_wr_ready", 32'(b1.wr_ready), 32'd1);
    applyStimulus(1'b0, 8'd7, 1'b1, 8'd0, 16'h0, 1'b1, 1'b1);
    checkOutput("ur_redisplay", 32'(b1.rd_data), 32'h7777);
    applyStimulus(1'b1, 8'd0, 1'b0, 8'd3, 16'h3333, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd0, 1'b1, 8'd0, 16'h0, 1'b1, 1'b0);
    checkOutput("ur_swap3_front", 32'(b1.front_bank), 32'd1);
    checkOutput("ur_swap3_pulse", 32'(b1.swap), 32'd1);
    checkOutput("ur_sticky", 32'(b1.underrun), 32'd1);

    // Clear underrun, then commit and consume on the same edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst2_underrun", 32'(b1.underrun), 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 8'd0, 1'b1, 8'd0, 16'h0, 1'b0, 1'b0);
    checkOutput("both_front", 32'(b1.front_bank), 32'd1);
    checkOutput("both_swap", 32'(b1.swap), 32'd1);
    checkOutput("both_wr_ready", 32'(b1.wr_ready), 32'd1);
    checkOutput("both_underrun", 32'(b1.underrun), 32'd0);

    // Asynchronous reset from FULL with front bank 1.
    applyStimulus(1'b1, 8'd0, 1'b1, 8'd0, 16'h0, 1'b0, 1'b1);
    checkOutput("pre_arst_wr_ready", 32'(b1.wr_ready), 32'd0);
    checkOutput("pre_arst_front", 32'(b1.front_bank), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_wr_ready", 32'(b1.wr_ready), 32'd1);
    checkOutput("arst_front", 32'(b1.front_bank), 32'd0);
    checkOutput("arst_rd_data", 32'(b1.rd_data), 32'd0);
    applyStimulus(1'b0, 8'd3, 1'b0, 8'd3, 16'hDEAD, 1'b0, 1'b0);
    checkOutput("inrst_front", 32'(b1.front_bank), 32'd0);
    checkOutput("inrst_swap", 32'(b1.swap), 32'd0);
    checkOutput("inrst_rd_data", 32'(b1.rd_data), 32'd0);
    rst = 1'b0;

    // Bank 1 words survive reset and show after the next swap.
    applyStimulus(1'b1, 8'd0, 1'b1, 8'd0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd0, 1'b1, 8'd0, 16'h0, 1'b1, 1'b0);
    checkOutput("post_rst_front", 32'(b1.front_bank), 32'd1);
    applyStimulus(1'b0, 8'd3, 1'b1, 8'd0, 16'h0, 1'b1, 1'b1);
    checkOutput("post_rst_read", 32'(b1.rd_data), 32'h3333);

    // Small instance: top address and address 0 stay in their own banks.
    applySmall(1'b1, 4'd0, 1'b0, 4'd15, 8'h5A, 1'b0, 1'b1);
    applySmall(1'b1, 4'd0, 1'b1, 4'd0, 8'h00, 1'b1, 1'b0);
    checkOutput("sm_front", 32'(b2.front_bank), 32'd1);
    checkOutput("sm_swap", 32'(b2.swap), 32'd1);
    applySmall(1'b0, 4'd15, 1'b0, 4'd15, 8'hC3, 1'b1, 1'b1);
    checkOutput("sm_read15", 32'(b2.rd_data), 32'h5A);
    applySmall(1'b0, 4'd15, 1'b0, 4'd0, 8'h3C, 1'b0, 1'b1);
    checkOutput("sm_read15_again", 32'(b2.rd_data), 32'h5A);
    applySmall(1'b1, 4'd0, 1'b1, 4'd0, 8'h00, 1'b1, 1'b0);
    checkOutput("sm_front2", 32'(b2.front_bank), 32'd0);
    applySmall(1'b0, 4'd15, 1'b1, 4'd0, 8'h00, 1'b1, 1'b1);
    checkOutput("sm_read15_b0", 32'(b2.rd_data), 32'hC3);
    applySmall(1'b0, 4'd0, 1'b1, 4'd0, 8'h00, 1'b1, 1'b1);
    checkOutput("sm_read0_b0", 32'(b2.rd_data), 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/chrowbuf_db.md
CHROWBUF_DB -- requirements
Module: chrowbuf_db

Interface
REQ-001 Parameter: DATA_W, default 16, width of one attr/code word.
REQ-002 Parameter: ADDR_W, default 8, address width; each bank holds 2**ADDR_W words.
REQ-003 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: rd  input  1  read enable, active-low.
REQ-006 Port: rd_addr  input  ADDR_W  word address in front bank.
REQ-007 Port: rd_data  output  DATA_W  registered read data.
REQ-008 Port: wr  input  1  write enable, active-low.
REQ-009 Port: wr_addr  input  ADDR_W  word address in back bank.
REQ-010 Port: wr_data  input  DATA_W  word to write.
REQ-011 Port: fill_done  input  1  active-low, one cycle: writer has finished the back bank.
REQ-012 Port: row_done  input  1  active-low, one cycle: reader has finished the front bank.
REQ-013 Port: front_bank  output  1  index of the bank currently read.
REQ-014 Port: wr_ready  output  1  high when back-bank writes are accepted.
REQ-015 Port: swap  output  1  one-cycle high pulse on the cycle after a bank swap.
REQ-016 Port: underrun  output  1  sticky flag: row_done arrived before the back bank was committed.

Function
REQ-017 Storage SHALL be 2*2**ADDR_W x DATA_W words, addressed {bank, addr}, inferable as block RAM with one read and one write port.
REQ-018 Read: rd=0 at edge N -> rd_data = mem[{front_bank, rd_addr}] after edge N (1-cycle latency); rd=1 -> rd_data holds its value.
REQ-019 Write: wr=0 and wr_ready=1 at edge N -> mem[{~front_bank, wr_addr}] = wr_data; wr=0 with wr_ready=0 SHALL be ignored, with memory unchanged.
REQ-020 State machine, two states: FILLING (wr_ready=1) and FULL (wr_ready=0).
REQ-021 FILLING, fill_done=0, row_done=1 -> FULL.
REQ-022 FULL, row_done=0 -> toggle front_bank, swap=1 next cycle, -> FILLING.
REQ-023 FILLING, row_done=0, fill_done=1 -> set underrun, no toggle, no swap, stay FILLING; old front bank is redisplayed.
REQ-024 FILLING, fill_done=0 and row_done=0 in the same cycle -> commit and swap in that edge: toggle front_bank, swap=1, stay FILLING, underrun unchanged.
REQ-025 FULL, fill_done=0 SHALL be ignored.
REQ-026 A write on the same edge as fill_done=0 in FILLING SHALL be accepted into the committed bank.
REQ-027 A read on the same edge as a toggle SHALL use the pre-toggle front_bank.
REQ-028 Read and write to the same {bank, addr} cannot occur by construction (the write bank is always ~front_bank); no bypass logic.
REQ-029 swap SHALL be high for exactly one cycle per toggle.
REQ-030 underrun SHALL stay set until rst.

Reset
REQ-031 rst=1 SHALL immediately force: state FILLING, front_bank=0, wr_ready=1, rd_data=0, swap=0, underrun=0.
REQ-032 While rst=1, reads, writes, fill_done and row_done SHALL be ignored. Memory contents are not cleared.
REQ-033 rst asserted mid-fill SHALL discard the commit state. Words already written remain in bank 1 but are not displayed until a later fill_done/row_done swap.

Verification
REQ-034 Reset, then write 0xA541 to addr 5 and pulse fill_done. Pulse row_done -> swap=1 for one cycle, front_bank=1. Then rd=0, addr 5 -> rd_data=0xA541 one cycle later.
REQ-035 In FULL, wr=0 addr 5 data 0x1234 -> memory unchanged. A later read after swap returns the prior value.
REQ-036 row_done=0 in FILLING with no fill_done -> underrun=1, front_bank unchanged, swap=0. underrun remains 1 across a later normal swap.
REQ-037 fill_done=0 and row_done=0 on the same edge in FILLING -> front_bank toggles, swap=1, wr_ready=1, underrun=0.
REQ-038 Assert rst asynchronously between edges while in FULL with front_bank=1 -> outputs take reset values before the next edge; wr_ready=1, front_bank=0.
REQ-039 Parameter sweep with DATA_W=8, ADDR_W=4: write addr 15 then swap -> read addr 15 returns the written value; addr wrap stays within the bank.
